// File: rtl/moving_avg_filter_if.sv
// moving_avg_filter_if: sample stream and control bundle for the moving average filter
// master drives start/clear/in_valid/in_sample; slave (the filter) drives out_valid/result/primed
interface moving_avg_filter_if #(parameter int DATA_W = 8);
  logic start;
  logic clear;
  logic in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic out_valid;
  logic signed [DATA_W-1:0] result;
  logic primed;
  modport master(output start, clear, in_valid, in_sample, input out_valid, result, primed);
  modport slave(input start, clear, in_valid, in_sample, output out_valid, result, primed);
endinterface

// File: rtl/moving_avg_filter.sv
// moving_avg_filter: signed moving average over a 2**LOG2_TAPS sample window
// CLK100MHZ: clock; reset: sync active-high; bus.slave: start/clear/in_valid/in_sample in,
// out_valid/result/primed out (result one cycle after each accepted sample)
module moving_avg_filter #(
  parameter int DATA_W = 8,
  parameter int LOG2_TAPS = 2
) (
  input logic CLK100MHZ,
  input logic reset,
  moving_avg_filter_if.slave bus
);
  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW = DATA_W + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] FULL = (LOG2_TAPS + 1)'(TAPS);
  logic signed [DATA_W-1:0] buf_q [TAPS];
  logic [LOG2_TAPS-1:0] ptr;
  logic [LOG2_TAPS:0] fill;
  logic signed [SW-1:0] sum, sum_nxt;
  logic acc;
  assign acc = bus.start && !bus.clear && bus.in_valid;
  // oldest entry leaves the window as the new sample enters; SW bits cannot overflow
  assign sum_nxt = sum + {{LOG2_TAPS{bus.in_sample[DATA_W-1]}}, bus.in_sample}
                       - {{LOG2_TAPS{buf_q[ptr][DATA_W-1]}}, buf_q[ptr]};
  assign bus.primed = (fill == FULL);
  always_ff @(posedge CLK100MHZ) begin
    if (reset || (bus.start && bus.clear)) begin
      for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
      ptr <= '0;
      fill <= '0;
      sum <= '0;
      bus.out_valid <= 1'b0;
      bus.result <= '0;
    end else if (acc) begin
      buf_q[ptr] <= bus.in_sample;
      ptr <= ptr + LOG2_TAPS'(1);
      fill <= (fill == FULL) ? fill : fill + (LOG2_TAPS + 1)'(1);
      sum <= sum_nxt;
      bus.out_valid <= 1'b1;
      bus.result <= DATA_W'(sum_nxt >>> LOG2_TAPS);
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_moving_avg_filter.sv
// tb_moving_avg_filter: directed self-checking bench for moving_avg_filter (DATA_W=8, 4 taps)
module tb_moving_avg_filter;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  moving_avg_filter_if #(.DATA_W(8)) bus ();
  moving_avg_filter #(.DATA_W(8), .LOG2_TAPS(2)) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic r, input logic s, input logic c, input logic v, input int d);
    reset = r;
    bus.start = s;
    bus.clear = c;
    bus.in_valid = v;
    bus.in_sample = 8'(d);
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk(input string tag, input logic ov, input int res, input logic pr);
    chk1({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    chk1({tag, ".result"}, 32'(bus.result), 32'(res));
    chk1({tag, ".primed"}, {31'd0, bus.primed}, {31'd0, pr});
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0);
    chk("reset", 0, 0, 0);
    cyc(0, 1, 0, 1, 4);    chk("ramp4", 1, 1, 0);
    cyc(0, 1, 0, 1, 8);    chk("ramp8", 1, 3, 0);
    cyc(0, 1, 0, 1, 12);   chk("ramp12", 1, 6, 0);
    cyc(0, 1, 0, 1, 16);   chk("ramp16", 1, 10, 1);
    cyc(0, 1, 0, 0, 0);    chk("ramp_idle", 0, 10, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, -128); chk("neg1", 1, -32, 0);
    cyc(0, 1, 0, 1, -128); chk("neg2", 1, -64, 0);
    cyc(0, 1, 0, 1, -128); chk("neg3", 1, -96, 0);
    cyc(0, 1, 0, 1, -128); chk("neg4", 1, -128, 1);
    cyc(0, 1, 0, 1, 127);  chk("swing1", 1, -65, 1);
    cyc(0, 1, 0, 1, 127);  chk("swing2", 1, -1, 1);
    cyc(0, 1, 0, 1, 127);  chk("swing3", 1, 63, 1);
    cyc(0, 1, 0, 1, 127);  chk("swing4", 1, 127, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, -1);   chk("minus1", 1, -1, 0);
    cyc(0, 1, 0, 0, 0);    chk("minus1_idle", 0, -1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 10);   chk("pause10", 1, 2, 0);
    cyc(0, 1, 0, 1, 20);   chk("pause20", 1, 7, 0);
    cyc(0, 0, 0, 1, 30);   chk("paused1", 0, 7, 0);
    cyc(0, 0, 1, 1, 30);   chk("paused_clear", 0, 7, 0);
    cyc(0, 0, 0, 1, 30);   chk("paused3", 0, 7, 0);
    cyc(0, 1, 0, 1, 30);   chk("resume30", 1, 15, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 40);   chk("flat1", 1, 10, 0);
    cyc(0, 1, 0, 1, 40);   chk("flat2", 1, 20, 0);
    cyc(0, 1, 0, 1, 40);   chk("flat3", 1, 30, 0);
    cyc(0, 1, 0, 1, 40);   chk("flat4", 1, 40, 1);
    cyc(0, 1, 1, 1, 100);  chk("clear", 0, 0, 0);
    cyc(0, 1, 0, 1, 8);    chk("after_clear", 1, 2, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 64);   chk("pre_rst1", 1, 16, 0);
    cyc(0, 1, 0, 1, 64);   chk("pre_rst2", 1, 32, 0);
    cyc(0, 1, 0, 1, 64);   chk("pre_rst3", 1, 48, 0);
    cyc(1, 1, 0, 1, 64);   chk("mid_reset", 0, 0, 0);
    cyc(0, 1, 0, 1, 64);   chk("post_rst", 1, 16, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
